// File: rtl/sf_window_avg_if.sv
// Sample-stream bundle between the accelerometer source and the window-average filter.
interface sf_window_avg_if #(
  parameter int WIDTH = 16,
  parameter int SEL_W = 3
) ();
  logic             enclk;
  logic [SEL_W-1:0] select;
  logic [WIDTH-1:0] acc_in;
  logic [WIDTH-1:0] smooth_out;
  logic             out_valid;
  logic             primed;

  modport master (
    output enclk, select, acc_in,
    input  smooth_out, out_valid, primed
  );

  modport slave (
    input  enclk, select, acc_in,
    output smooth_out, out_valid, primed
  );
endinterface

// File: rtl/sf_window_avg.sv
// Moving-average smoother over a 2^k sample window using a circular buffer and a running sum.
// A change of window size flushes the running state; partially filled windows pass samples through.
module sf_window_avg #(
  parameter int WIDTH    = 16,
  parameter int MAX_LOG2 = 4,
  parameter int SEL_W    = 3,
  parameter int ROUND    = 0
) (
  input logic             clk,
  input logic             reset,
  sf_window_avg_if.slave  bus
);
  localparam int DEPTH  = 1 << MAX_LOG2;
  localparam int SUM_W  = WIDTH + MAX_LOG2;
  localparam int FILL_W = MAX_LOG2 + 1;

  logic [WIDTH-1:0]    sample_buf_r [DEPTH];
  logic [MAX_LOG2-1:0] wr_ptr_r;
  logic [SUM_W-1:0]    sum_r;
  logic [FILL_W-1:0]   fill_r;
  logic [SEL_W-1:0]    k_q_r;

  logic [SEL_W-1:0]    k_s;
  logic [FILL_W-1:0]   n_s;
  logic                flush_s;
  logic [MAX_LOG2-1:0] rd_idx_s;
  logic [SUM_W-1:0]    old_s;
  logic [SUM_W-1:0]    sum_n_s;
  logic [FILL_W-1:0]   fill_n_s;
  logic [SUM_W-1:0]    rnd_s;
  logic [SUM_W-1:0]    mean_s;

  // Next-state arithmetic for the running sum, fill level and window mean.
  always_comb begin
    k_s      = (bus.select > SEL_W'(MAX_LOG2)) ? SEL_W'(MAX_LOG2) : bus.select;
    n_s      = FILL_W'(1) << k_s;
    flush_s  = (k_s != k_q_r);
    // When N == DEPTH the low bits of N are zero, so the oldest entry sits at wr_ptr itself.
    rd_idx_s = wr_ptr_r - n_s[MAX_LOG2-1:0];
    old_s    = '0;
    if (fill_r == n_s) begin
      old_s = SUM_W'(sample_buf_r[rd_idx_s]);
    end else begin
      old_s = '0;
    end
    if (flush_s) begin
      sum_n_s  = SUM_W'(bus.acc_in);
      fill_n_s = FILL_W'(1);
    end else begin
      sum_n_s  = sum_r + SUM_W'(bus.acc_in) - old_s;
      fill_n_s = (fill_r == n_s) ? fill_r : fill_r + FILL_W'(1);
    end
    if ((ROUND != 32'sd0) && (k_s != SEL_W'(0))) begin
      rnd_s = SUM_W'(1) << (k_s - SEL_W'(1));
    end else begin
      rnd_s = '0;
    end
    mean_s = (sum_n_s + rnd_s) >> k_s;
  end

  // Sample history; never read before rewritten, so it carries no reset.
  always_ff @(posedge clk) begin
    if (bus.enclk) begin
      sample_buf_r[wr_ptr_r] <= bus.acc_in;
    end
  end

  // Filter state and registered outputs; a flush is overridden by a same-edge sample.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r       <= '0;
      sum_r          <= '0;
      fill_r         <= '0;
      k_q_r          <= '0;
      bus.smooth_out <= '0;
      bus.out_valid  <= 1'b0;
      bus.primed     <= 1'b0;
    end else begin
      if (flush_s) begin
        k_q_r      <= k_s;
        sum_r      <= '0;
        fill_r     <= '0;
        bus.primed <= 1'b0;
      end
      if (bus.enclk) begin
        sum_r         <= sum_n_s;
        fill_r        <= fill_n_s;
        wr_ptr_r      <= wr_ptr_r + MAX_LOG2'(1);
        bus.out_valid <= 1'b1;
        if (fill_n_s == n_s) begin
          bus.smooth_out <= mean_s[WIDTH-1:0];
          bus.primed     <= 1'b1;
        end else begin
          bus.smooth_out <= bus.acc_in;
          bus.primed     <= 1'b0;
        end
      end else begin
        bus.out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_sf_window_avg.sv
// Directed and randomized bench for sf_window_avg; a truncating and a rounding instance share stimulus.
module tb_sf_window_avg;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  sf_window_avg_if #(.WIDTH(16), .SEL_W(3)) bus0 ();
  sf_window_avg_if #(.WIDTH(16), .SEL_W(3)) bus1 ();

  sf_window_avg #(.WIDTH(16), .MAX_LOG2(4), .SEL_W(3), .ROUND(0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
  sf_window_avg #(.WIDTH(16), .MAX_LOG2(4), .SEL_W(3), .ROUND(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

  always #5 clk = ~clk;

  // Reference model: sample history since the last flush, window mean computed directly from it.
  int          mk;
  int          hist[$];
  logic [15:0] e_trunc;
  logic [15:0] e_round;
  logic        e_valid;
  logic        e_primed;

  task automatic model_reset();
    mk = 0;
    hist.delete();
    e_trunc  = 16'h0000;
    e_round  = 16'h0000;
    e_valid  = 1'b0;
    e_primed = 1'b0;
  endtask

  task automatic model_edge(input logic en, input int sel, input int d);
    int     k;
    int     n;
    longint s;
    k = (sel > 4) ? 4 : sel;
    if (k != mk) begin
      mk = k;
      hist.delete();
      e_primed = 1'b0;
    end
    if (!en) begin
      e_valid = 1'b0;
      return;
    end
    hist.push_back(d);
    if (hist.size() > 16) void'(hist.pop_front());
    n = 1 << mk;
    e_valid = 1'b1;
    if (hist.size() < n) begin
      e_trunc  = d[15:0];
      e_round  = d[15:0];
      e_primed = 1'b0;
    end else begin
      s = 0;
      for (int i = hist.size() - n; i < hist.size(); i++) s += hist[i];
      e_trunc  = 16'(s / n);
      e_round  = (mk == 0) ? 16'(s) : 16'((s + n / 2) / n);
      e_primed = 1'b1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "/trunc_out"},   32'(bus0.smooth_out), 32'(e_trunc));
    check({tag, "/trunc_valid"}, 32'(bus0.out_valid),  32'(e_valid));
    check({tag, "/trunc_primed"},32'(bus0.primed),     32'(e_primed));
    check({tag, "/round_out"},   32'(bus1.smooth_out), 32'(e_round));
    check({tag, "/round_valid"}, 32'(bus1.out_valid),  32'(e_valid));
    check({tag, "/round_primed"},32'(bus1.primed),     32'(e_primed));
  endtask

  task automatic drive(input logic en, input logic [2:0] sel, input logic [15:0] d);
    bus0.enclk = en; bus0.select = sel; bus0.acc_in = d;
    bus1.enclk = en; bus1.select = sel; bus1.acc_in = d;
  endtask

  task automatic step(input string tag, input logic en, input logic [2:0] sel, input logic [15:0] d);
    @(negedge clk);
    drive(en, sel, d);
    @(posedge clk);
    model_edge(en, int'(sel), int'(d));
    #1;
    check_all(tag);
  endtask

  initial begin
    drive(1'b0, 3'd0, 16'h0000);
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    reset = 1'b0;

    step("n1_a", 1'b1, 3'd0, 16'd5);
    step("n1_b", 1'b1, 3'd0, 16'd9);

    step("n4_a", 1'b1, 3'd2, 16'd4);
    step("n4_b", 1'b1, 3'd2, 16'd8);
    step("n4_c", 1'b1, 3'd2, 16'd12);
    step("n4_d", 1'b1, 3'd2, 16'd16);
    check("n4_mean10", 32'(bus0.smooth_out), 32'd10);
    step("n4_e", 1'b1, 3'd2, 16'd20);
    check("n4_mean14", 32'(bus0.smooth_out), 32'd14);

    step("n2_a", 1'b1, 3'd1, 16'd1);
    step("n2_b", 1'b1, 3'd1, 16'd2);
    check("trunc_1_2", 32'(bus0.smooth_out), 32'd1);
    check("round_1_2", 32'(bus1.smooth_out), 32'd2);

    // Prime a 4-window, then widen to 8 with a sample on the change edge.
    for (int i = 0; i < 5; i++) step("pre_sw", 1'b1, 3'd2, 16'($urandom));
    for (int i = 0; i < 10; i++) step("sw_8", 1'b1, 3'd3, 16'($urandom));

    for (int i = 0; i < 20; i++) step("full_ffff", 1'b1, 3'd4, 16'hFFFF);
    check("ffff_mean", 32'(bus0.smooth_out), 32'h0000FFFF);

    for (int i = 0; i < 20; i++) step("sel7", 1'b1, 3'd7, 16'($urandom));
    for (int i = 0; i < 10; i++) step("hold", 1'b0, 3'd7, 16'($urandom));

    // Asynchronous reset landing between clock edges.
    for (int i = 0; i < 6; i++) step("pre_rst", 1'b1, 3'd2, 16'($urandom));
    @(negedge clk);
    drive(1'b0, 3'd2, 16'h0000);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    #1 reset = 1'b0;
    step("post_rst", 1'b1, 3'd2, 16'd77);
    check("post_rst_pass", 32'(bus0.smooth_out), 32'd77);

    for (int i = 0; i < 400; i++) begin
      logic [2:0] sel;
      sel = ($urandom_range(0, 9) == 0) ? 3'($urandom) : bus0.select;
      step("random", 1'($urandom_range(0, 3) != 0), sel, 16'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
